fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction and address width.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port imem_req  output  1  fetch request valid this cycle.
REQ-007 SHALL have port imem_addr  output  DATA_WIDTH  fetch byte address (word-aligned).
REQ-008 SHALL have port imem_rvalid  input  1  response valid, exactly one cycle after the request.
REQ-009 SHALL have port imem_rdata  input  DATA_WIDTH  instruction word.
REQ-010 SHALL have port redirect  input  1  taken branch/jump (PCsrc) pulse.
REQ-011 SHALL have port redirect_pc  input  DATA_WIDTH  new fetch target.
REQ-012 SHALL have port instr_valid  output  1  queue head valid.
REQ-013 SHALL have port instr_ready  input  1  decode accepts head.
REQ-014 SHALL have port instr  output  DATA_WIDTH  head instruction word.
REQ-015 SHALL have port instr_pc  output  DATA_WIDTH  PC of head instruction.

Function
REQ-016 SHALL hold fetch_pc; each issued request uses imem_addr = fetch_pc, then fetch_pc += 4, wrapping modulo 2^DATA_WIDTH.
REQ-017 SHALL assert imem_req only when occupancy + in-flight responses < DEPTH (credit rule; queue never overflows).
REQ-018 SHALL write {imem_rdata, request PC} into the queue at end of the cycle imem_rvalid is high, unless discarded; entry visible at instr_valid the next cycle.
REQ-019 SHALL pop the head when instr_valid && instr_ready; instr/instr_pc SHALL be stable while instr_valid && !instr_ready.
REQ-020 SHALL support simultaneous push and pop in one cycle with occupancy unchanged.
REQ-021 SHALL implement states FETCH and FLUSH; FETCH->FLUSH on redirect; FLUSH->FETCH if no redirect, FLUSH->FLUSH on redirect.
REQ-022 On redirect (any state) SHALL empty the queue, set fetch_pc = {redirect_pc[31:2], 2'b00}, ignore instr_ready that cycle.
REQ-023 In FLUSH SHALL discard any imem_rvalid (stale response) and SHALL issue the request for the redirect target.
REQ-024 Redirect at cycle t SHALL yield imem_addr = target at t+1 and instr_valid with instr_pc = target at t+3.
REQ-025 Redirect SHALL have priority over push and pop in the same cycle.
REQ-026 imem_rvalid without an outstanding request SHALL be ignored.

Reset
REQ-027 While rst low: imem_req=0, instr_valid=0, queue empty, in-flight=0, fetch_pc=RESET_PC, state=FETCH; instr/instr_pc don't-care.
REQ-028 First request (imem_addr=RESET_PC) SHALL issue in the first clock after rst deasserts; reset mid-operation SHALL drop all entries and in-flight responses.

Configuration
REQ-029 With FETCH_QUEUE_STATS_EN defined, SHALL add output flush_count (16 bits): saturating count of valid entries plus in-flight responses discarded by redirects, reset to 0.
REQ-030 Without FETCH_QUEUE_STATS_EN, flush_count port and logic SHALL be absent; other behaviour identical.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the state enum (FETCH, FLUSH), INSTR_BYTES=4 and default RESET_PC.
REQ-032 Storage SHALL be a sub-module sync_fifo (width 2*DATA_WIDTH, depth DEPTH, with flush input); control, credit and PC logic stay in fetch_queue.

Verification
REQ-033 Reset release, instr_ready=1, memory returns addr^32'hA5A5_0000 -> instr_pc 0,4,8,... one per cycle from cycle 3, no gaps.
REQ-034 instr_ready=0 for 10 cycles -> exactly DEPTH=4 requests (0x0..0xC), imem_req low afterwards, head stays pc=0 stable.
REQ-035 Redirect to 0x0000_0103 at cycle 6 with queue partly full -> rvalid at cycle 7 dropped, imem_addr=0x100 at 7, instr_pc=0x100 at 9, no old PC ever emitted after redirect.
REQ-036 Back-to-back redirects to 0x200 then 0x300 -> only 0x300 stream delivered; with STATS_EN flush_count equals dropped entries.
REQ-037 fetch_pc=0xFFFF_FFFC -> next request 0x0000_0000.
REQ-038 rst asserted mid-stream with 3 entries queued -> instr_valid 0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: FSM states, instruction
// size, default reset PC and a saturating-add helper for the flush statistics.
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fq_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // 16-bit add that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO holding {instruction, pc} entries for fetch_queue.
// Flush empties the queue in one cycle and overrides push/pop. Overflow is
// prevented upstream by the credit rule, so no full flag is needed.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  // storage array: data only, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  // pointer and occupancy bookkeeping; flush wins over push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word fetches under a credit rule, queues the
// one-cycle-latency responses, and handles branch redirects by flushing the
// queue and discarding the stale response that is still in flight.
// Optional feature: define FETCH_QUEUE_STATS_EN to add the flush_count output.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]           flush_count
`endif
);

  localparam int                    CW   = $clog2(DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(INSTR_BYTES);

  fq_state_e             state_q;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] req_pc;     // pc of the request whose response is due
  logic                  inflight;   // a request was issued last cycle
  logic [CW-1:0]         occ;
  logic [CW:0]           credit_use;
  logic                  fifo_empty;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] target;
  logic [2*DATA_WIDTH-1:0] head;
  logic                  unused_lsb;

  // word-align the redirect target; the low bits carry no information
  assign target     = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign unused_lsb = ^redirect_pc[1:0];

  // credit rule: queued entries plus the outstanding response must leave room
  assign credit_use = {1'b0, occ} + (CW+1)'(inflight);
  assign imem_req   = rst && (credit_use < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc;

  // redirect beats push and pop; FLUSH drops the stale response
  assign push = imem_rvalid && inflight && (state_q == FETCH) && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  assign instr_valid = !fifo_empty;
  assign instr       = head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign instr_pc    = head[DATA_WIDTH-1:0];

  // FETCH/FLUSH: FLUSH lasts exactly the cycle after each redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= redirect ? FLUSH : FETCH;
  end

  // fetch pc and in-flight tracking; a redirect cancels the outstanding credit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + STEP;
      end
    end
  end

  sync_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .wdata ({imem_rdata, req_pc}),
    .pop   (pop),
    .rdata (head),
    .count (occ),
    .empty (fifo_empty)
  );

`ifdef FETCH_QUEUE_STATS_EN
  logic [CW:0] dropped;

  // words lost to a redirect: queued entries, the response arriving now, and
  // the request issued this cycle whose response lands in FLUSH
  assign dropped = credit_use + (CW+1)'(imem_req);

  // saturating flush statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          flush_count <= '0;
    else if (redirect) flush_count <= sat_add16(flush_count, 16'(dropped));
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: hand-written vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_count;
`endif

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // memory: answers every request one cycle later with addr ^ K
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;

  // reference model: queue contents, outstanding request, next fetch address
  logic [31:0] mq_pc[$];
  logic [31:0] mq_data[$];
  logic        m_pend;
  logic [31:0] m_pend_pc, m_fetch_pc;
  int          m_fc;

  // snapshot of the DUT outputs taken mid-cycle
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [31:0] emitted[$];

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_data.delete();
    m_pend     = 1'b0;
    m_pend_pc  = '0;
    m_fetch_pc = 32'h0;
    m_fc       = 0;
  endtask

  // one clock: drive at the falling edge, sample 1 ns later, advance model
  task automatic cycle(input logic r, input logic rdy, input logic redir, input logic [31:0] tgt);
    logic e_req, e_vld;
    int   sz;
    rst         = r;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    imem_rvalid = mem_pend;
    imem_rdata  = mem_addr ^ K;
    #1;
    if (!r) model_reset();
    sz    = mq_pc.size();
    e_req = r && ((sz + int'(m_pend)) < DEPTH);
    e_vld = (sz > 0);
    s_req = imem_req; s_addr = imem_addr; s_vld = instr_valid;
    s_pc  = instr_pc; s_instr = instr;
    chk("model imem_req", imem_req, e_req);
    if (e_req) chk("model imem_addr", imem_addr, m_fetch_pc);
    chk("model instr_valid", instr_valid, e_vld);
    if (e_vld) begin
      chk("model instr_pc", instr_pc, mq_pc[0]);
      chk("model instr", instr, mq_data[0]);
    end
`ifdef FETCH_QUEUE_STATS_EN
    chk("model flush_count", flush_count, 32'(m_fc));
`endif
    if (r && instr_valid && rdy && !redir) emitted.push_back(instr_pc);
    mem_pend = imem_req;
    mem_addr = imem_addr;
    if (r) begin
      if (redir) begin
        m_fc = m_fc + sz + int'(m_pend) + int'(e_req);
        if (m_fc > 65535) m_fc = 65535;
        mq_pc.delete();
        mq_data.delete();
        m_pend     = 1'b0;
        m_fetch_pc = tgt & 32'hFFFF_FFFC;
      end else begin
        if (sz > 0 && rdy) begin
          void'(mq_pc.pop_front());
          void'(mq_data.pop_front());
        end
        if (imem_rvalid && m_pend) begin
          mq_pc.push_back(m_pend_pc);
          mq_data.push_back(imem_rdata);
        end
        m_pend = e_req;
        if (e_req) begin
          m_pend_pc  = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int nreq;
    logic [31:0] addrs[$];

    // rdy, redir, tgt, e_req, e_addr, e_vld, e_pc  (cycle 1 = first after reset)
    vt[0] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
    vt[1] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h000};
    vt[2] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000};
    vt[3] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004};
    vt[4] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h008};
    vt[5] = '{1'b1, 1'b1, 32'h103, 1'b1, 32'h014, 1'b1, 32'h00C};
    vt[6] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000};
    vt[7] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h000};
    vt[8] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};
    vt[9] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104};

    rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    model_reset();
    @(negedge clk);

    // reset state
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("reset imem_req", s_req, 1'b0);
    chk("reset instr_valid", s_vld, 1'b0);

    // streaming then redirect to 0x103 at cycle 6
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, vt[i].rdy, vt[i].redir, vt[i].tgt);
      chk($sformatf("vec%0d imem_req", i), s_req, vt[i].e_req);
      if (vt[i].e_req) chk($sformatf("vec%0d imem_addr", i), s_addr, vt[i].e_addr);
      chk($sformatf("vec%0d instr_valid", i), s_vld, vt[i].e_vld);
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d instr_pc", i), s_pc, vt[i].e_pc);
        chk($sformatf("vec%0d instr", i), s_instr, vt[i].e_pc ^ K);
      end
    end

    // decode stalled: exactly DEPTH requests then silence, head held
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    nreq = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      if (s_req) begin nreq++; addrs.push_back(s_addr); end
      if (c >= 3) chk("stall head pc", s_pc, 32'h0);
    end
    chk("stall request count", 32'(nreq), 32'd4);
    for (int i = 0; i < addrs.size() && i < 4; i++)
      chk("stall request addr", addrs[i], 32'(4*i));
    chk("stall req low", s_req, 1'b0);
    chk("stall head valid", s_vld, 1'b1);

    // back-to-back redirects: only the second stream is delivered
    cycle(1'b1, 1'b0, 1'b1, 32'h200);
    cycle(1'b1, 1'b0, 1'b1, 32'h300);
    emitted.delete();
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("b2b emitted count", 32'(emitted.size()), 32'd4);
    for (int i = 0; i < emitted.size(); i++)
      chk("b2b emitted pc", emitted[i], 32'h300 + 32'(4*i));
`ifdef FETCH_QUEUE_STATS_EN
    chk("b2b flush_count", 32'(flush_count), 32'd5);
`endif

    // fetch address wraps past the top of memory
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap first addr", s_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap next addr", s_addr, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap head pc", s_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap head pc next", s_pc, 32'h0);

    // reset with three entries queued
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre-reset head valid", s_vld, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mid reset instr_valid", s_vld, 1'b0);
    chk("mid reset imem_req", s_req, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart imem_req", s_req, 1'b1);
    chk("restart imem_addr", s_addr, 32'h0);
    chk("restart instr_valid", s_vld, 1'b0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic r, rdy, rd;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 199) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle(r, rdy, rd, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
